// File: rtl/page_pkg.sv
// Shared types and helpers for the page switch controller.
package page_pkg;

    // Scheduler states: waiting for a press, waiting for vblank, blanking frames.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BLANK   = 2'd2
    } page_state_t;

    localparam int DEF_NEXT_IDX = 0;
    localparam int DEF_PREV_IDX = 1;

    // Width of the page index for a given page count (count is at least 2).
    function automatic int page_idx_w(input int num_pages);
        return (num_pages < 2) ? 1 : $clog2(num_pages);
    endfunction

    // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for the raw button bus.
module btn_debounce
    import page_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEB_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btns_raw,
    output logic [WIDTH-1:0] btns_deb
);

    localparam int CNT_W = cnt_w(DEB_CYCLES);
    // Last count before acceptance; the accepting cycle is the DEB_CYCLES-th differing one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q;
    logic [WIDTH-1:0]            sync2_q;
    logic [WIDTH-1:0]            deb_q;
    logic [WIDTH-1:0]            deb_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // Bring the asynchronous button levels into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btns_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level once the count completes.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounced level and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign btns_deb = deb_q;

endmodule

// File: rtl/page_switch_ctrl.sv
// Page scheduler: turns debounced next/prev presses into page changes committed at
// vblank, followed by a run of black frames; gates button forwarding meanwhile.
module page_switch_ctrl
    import page_pkg::*;
#(
    parameter int NUM_PAGES    = 3,
    parameter int BTN_W        = 16,
    parameter int NEXT_IDX     = DEF_NEXT_IDX,
    parameter int PREV_IDX     = DEF_PREV_IDX,
    parameter int DEB_CYCLES   = 65536,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BTN_W-1:0]             btns_raw,
    input  logic                         vblank,
    output logic [$clog2(NUM_PAGES)-1:0] page_sel,
    output logic                         blank,
    output logic [BTN_W-1:0]             btns_fwd
);

    localparam int PAGE_W     = page_idx_w(NUM_PAGES);
    localparam int PAGE_EXT_W = PAGE_W + 1;
    localparam int FRAME_W    = cnt_w(BLANK_FRAMES);

    localparam logic [PAGE_W-1:0]     PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [PAGE_EXT_W-1:0] PAGE_COUNT = PAGE_EXT_W'(NUM_PAGES);
    // Unreachable when BLANK_FRAMES is 0 since BLANK is then never entered.
    localparam logic [FRAME_W-1:0]    FRAME_LAST = FRAME_W'(BLANK_FRAMES - 1);

    logic [BTN_W-1:0]      btns_deb;
    logic [BTN_W-1:0]      btns_masked;
    logic [BTN_W-1:0]      btns_fwd_q;
    logic [BTN_W-1:0]      btns_fwd_d;

    logic                  next_last_q;
    logic                  prev_last_q;
    logic                  press_next_q;
    logic                  press_prev_q;
    logic                  vblank_last_q;
    logic                  vblank_rise;

    page_state_t           state_q;
    page_state_t           state_d;
    logic                  dir_up_q;
    logic                  dir_up_d;
    logic [PAGE_W-1:0]     page_q;
    logic [PAGE_W-1:0]     page_d;
    logic [FRAME_W-1:0]    frame_cnt_q;
    logic [FRAME_W-1:0]    frame_cnt_d;

    logic [PAGE_EXT_W-1:0] page_inc_ext;
    logic [PAGE_EXT_W-1:0] page_dec_ext;
    logic [PAGE_W-1:0]     page_inc;
    logic [PAGE_W-1:0]     page_dec;

    btn_debounce #(
        .WIDTH      (BTN_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .btns_raw (btns_raw),
        .btns_deb (btns_deb)
    );

    // One-cycle press events on debounced rises, plus vblank history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_last_q   <= 1'b0;
            prev_last_q   <= 1'b0;
            press_next_q  <= 1'b0;
            press_prev_q  <= 1'b0;
            vblank_last_q <= 1'b0;
        end else begin
            next_last_q   <= btns_deb[NEXT_IDX];
            prev_last_q   <= btns_deb[PREV_IDX];
            press_next_q  <= btns_deb[NEXT_IDX] & ~next_last_q;
            press_prev_q  <= btns_deb[PREV_IDX] & ~prev_last_q;
            vblank_last_q <= vblank;
        end
    end

    assign vblank_rise = vblank & ~vblank_last_q;

    // Wrap arithmetic one bit wider than the index so both overflow and underflow are visible.
    always_comb begin
        page_inc_ext = {1'b0, page_q} + PAGE_EXT_W'(1);
        page_dec_ext = {1'b0, page_q} - PAGE_EXT_W'(1);
        page_inc     = (page_inc_ext == PAGE_COUNT) ? '0 : page_inc_ext[PAGE_W-1:0];
        page_dec     = (page_dec_ext == '1) ? PAGE_LAST : page_dec_ext[PAGE_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath updates; presses outside IDLE fall through unused.
    always_comb begin
        state_d     = state_q;
        dir_up_d    = dir_up_q;
        page_d      = page_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            IDLE: begin
                // Simultaneous next and prev cancel out.
                if (press_next_q ^ press_prev_q) begin
                    dir_up_d = press_next_q;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (vblank_rise) begin
                    page_d      = dir_up_q ? page_inc : page_dec;
                    frame_cnt_d = '0;
                    state_d     = (BLANK_FRAMES == 0) ? IDLE : BLANK;
                end
            end
            BLANK: begin
                if (vblank_rise) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: blank follows the state, forwarded buttons are masked then registered.
    always_comb begin
        btns_masked           = btns_deb;
        btns_masked[NEXT_IDX] = 1'b0;
        btns_masked[PREV_IDX] = 1'b0;
        blank                 = (state_q == BLANK);
        btns_fwd_d            = (state_q == IDLE) ? btns_masked : '0;
    end

    // Datapath registers: direction, page index, frame count, forwarded buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_up_q    <= 1'b0;
            page_q      <= '0;
            frame_cnt_q <= '0;
            btns_fwd_q  <= '0;
        end else begin
            dir_up_q    <= dir_up_d;
            page_q      <= page_d;
            frame_cnt_q <= frame_cnt_d;
            btns_fwd_q  <= btns_fwd_d;
        end
    end

    assign page_sel = page_q;
    assign btns_fwd = btns_fwd_q;

endmodule

// File: tb/tb_page_switch_ctrl.sv
// Self-checking bench for page_switch_ctrl: 100-cycle frames, vblank in the last 10.
module tb_page_switch_ctrl;

    localparam int NUM_PAGES    = 3;
    localparam int BTN_W        = 16;
    localparam int DEB_CYCLES   = 4;
    localparam int BLANK_FRAMES = 2;
    localparam int PW           = $clog2(NUM_PAGES);

    logic             clk = 1'b0;
    logic             rst;
    logic [BTN_W-1:0] btns_raw;
    logic             vblank;
    logic [PW-1:0]    page_sel;
    logic             blank;
    logic [BTN_W-1:0] btns_fwd;

    int n_vec = 0;
    int n_err = 0;
    int pos = 0;
    int model_page = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    page_switch_ctrl #(
        .NUM_PAGES    (NUM_PAGES),
        .BTN_W        (BTN_W),
        .NEXT_IDX     (0),
        .PREV_IDX     (1),
        .DEB_CYCLES   (DEB_CYCLES),
        .BLANK_FRAMES (BLANK_FRAMES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btns_raw (btns_raw),
        .vblank   (vblank),
        .page_sel (page_sel),
        .blank    (blank),
        .btns_fwd (btns_fwd)
    );

    // Frame generator: inputs change 1 time unit after the rising edge.
    initial begin
        vblank = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pos    = (pos == 99) ? 0 : pos + 1;
            vblank = (pos >= 90);
        end
    end

    // Scoreboard: every page change must match the queued expectation, land one cycle
    // after a vblank rise, and coincide with blank going high.
    initial begin
        logic [PW-1:0] last;
        logic          v1;
        logic          v2;
        int            e;
        last = '0;
        v1   = 1'b0;
        v2   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                last = page_sel;
            end else if (page_sel !== last) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL page_unexpected: page_sel=%0d, required=%0d", page_sel, last);
                end else begin
                    e = exp_q.pop_front();
                    if (page_sel !== PW'(e)) begin
                        n_err++;
                        $display("FAIL page_value: page_sel=%0d, required=%0d", page_sel, e);
                    end
                end
                n_vec++;
                if (!(v1 === 1'b1 && v2 === 1'b0)) begin
                    n_err++;
                    $display("FAIL page_timing: vblank rise one cycle earlier=0, required=1");
                end
                n_vec++;
                if (blank !== 1'b1) begin
                    n_err++;
                    $display("FAIL blank_with_page: blank=%b, required=1", blank);
                end
                last = page_sel;
            end
            v2 = v1;
            v1 = vblank;
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_pos(input int p);
        int k = 0;
        while (pos != p && k < 200) begin
            tick(1);
            k++;
        end
    endtask

    function automatic int step_page(input int p, input logic up);
        if (up) return (p == NUM_PAGES - 1) ? 0 : p + 1;
        return (p == 0) ? NUM_PAGES - 1 : p - 1;
    endfunction

    task automatic apply_reset();
        rst      = 1'b1;
        btns_raw = '0;
        tick(1);
        rst        = 1'b0;
        model_page = 0;
        exp_q.delete();
    endtask

    // Wait until a switch completes (blank high then low), bounded.
    task automatic wait_done(input string name);
        int k1 = 0;
        int k2 = 0;
        while (blank !== 1'b1 && k1 < 300) begin
            tick(1);
            k1++;
        end
        while (blank === 1'b1 && k2 < 400) begin
            tick(1);
            k2++;
        end
        n_vec++;
        if (k1 >= 300 || k2 >= 400) begin
            n_err++;
            $display("FAIL %s_timeout: switch not completed, waited %0d/%0d cycles", name, k1, k2);
        end
    endtask

    task automatic switch_once(input logic up, input string name);
        int idx;
        idx = up ? 0 : 1;
        wait_pos(20);
        model_page = step_page(model_page, up);
        exp_q.push_back(model_page);
        btns_raw[idx] = 1'b1;
        tick(20);
        btns_raw = '0;
        wait_done(name);
        n_vec++;
        if (page_sel !== PW'(model_page)) begin
            n_err++;
            $display("FAIL %s: page_sel=%0d, required=%0d", name, page_sel, model_page);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        btns_raw = '0;
        tick(3);
        n_vec++;
        if (page_sel !== '0) begin
            n_err++;
            $display("FAIL reset_page: page_sel=%0d, required=0", page_sel);
        end
        n_vec++;
        if (blank !== 1'b0) begin
            n_err++;
            $display("FAIL reset_blank: blank=%b, required=0", blank);
        end
        n_vec++;
        if (btns_fwd !== '0) begin
            n_err++;
            $display("FAIL reset_fwd: btns_fwd=%h, required=0000", btns_fwd);
        end
        rst = 1'b0;
        model_page = 0;
        exp_q.delete();
        tick(2);
    endtask

    task automatic test_next_press();
        int bad = 0;
        int hi;
        int k = 0;
        wait_pos(20);
        model_page = step_page(model_page, 1'b1);
        exp_q.push_back(model_page);
        btns_raw[0] = 1'b1;
        repeat (20) begin
            tick(1);
            if (btns_fwd !== '0) bad++;
        end
        btns_raw = '0;
        while (pos != 90 && k < 200) begin
            tick(1);
            k++;
            if (btns_fwd !== '0) bad++;
        end
        n_vec++;
        if (page_sel !== PW'(0)) begin
            n_err++;
            $display("FAIL next_before_rise: page_sel=%0d, required=0", page_sel);
        end
        tick(1);
        n_vec++;
        if (page_sel !== PW'(1)) begin
            n_err++;
            $display("FAIL next_after_rise: page_sel=%0d, required=1", page_sel);
        end
        hi = (blank === 1'b1) ? 1 : 0;
        while (blank === 1'b1 && hi < 500) begin
            tick(1);
            if (btns_fwd !== '0) bad++;
            if (blank === 1'b1) hi++;
        end
        n_vec++;
        if (hi != 200) begin
            n_err++;
            $display("FAIL next_blank_len: blank high %0d cycles, required 200", hi);
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL next_fwd_zero: %0d nonzero btns_fwd samples, required 0", bad);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        switch_once(1'b1, "wrap_0to1");
        switch_once(1'b1, "wrap_1to2");
        switch_once(1'b1, "wrap_2to0");
        switch_once(1'b0, "prev_0to2");
    endtask

    task automatic test_bounce_merge();
        int bad = 0;
        wait_pos(20);
        for (int i = 0; i < 15; i++) begin
            btns_raw[0] = ~btns_raw[0];
            tick(2);
        end
        btns_raw = '0;
        repeat (150) begin
            tick(1);
            if (blank !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || page_sel !== PW'(model_page)) begin
            n_err++;
            $display("FAIL bounce: page_sel=%0d blank_hits=%0d, required page %0d and 0 hits",
                     page_sel, bad, model_page);
        end
        // Next and prev rise together with bit 5: forwarding must stay on, so the FSM stayed IDLE.
        wait_pos(20);
        btns_raw = 16'h0023;
        tick(7);
        n_vec++;
        if (btns_fwd !== 16'h0020) begin
            n_err++;
            $display("FAIL merge_fwd: btns_fwd=%h, required 0020", btns_fwd);
        end
        bad = 0;
        repeat (150) begin
            tick(1);
            if (btns_fwd !== 16'h0020 || blank !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL merge_idle: %0d cycles left IDLE, required 0", bad);
        end
        btns_raw = '0;
        tick(10);
        n_vec++;
        if (page_sel !== PW'(model_page)) begin
            n_err++;
            $display("FAIL merge_page: page_sel=%0d, required=%0d", page_sel, model_page);
        end
    endtask

    task automatic test_fwd_mask();
        int  bad = 0;
        int  k = 0;
        logic seen = 1'b0;
        wait_pos(20);
        model_page = step_page(model_page, 1'b1);
        exp_q.push_back(model_page);
        btns_raw = 16'h0021;
        tick(6);
        n_vec++;
        if (btns_fwd !== 16'h0000) begin
            n_err++;
            $display("FAIL fwd_early: btns_fwd=%h, required 0000", btns_fwd);
        end
        tick(1);
        n_vec++;
        if (btns_fwd !== 16'h0020) begin
            n_err++;
            $display("FAIL fwd_mask: btns_fwd=%h, required 0020", btns_fwd);
        end
        tick(2);
        while (k < 700) begin
            if (btns_fwd !== '0) bad++;
            if (blank === 1'b1) seen = 1'b1;
            else if (seen) break;
            tick(1);
            k++;
        end
        n_vec++;
        if (bad != 0 || k >= 700) begin
            n_err++;
            $display("FAIL fwd_busy: %0d nonzero samples, loop %0d, required 0 and done", bad, k);
        end
        tick(1);
        n_vec++;
        if (btns_fwd !== 16'h0020) begin
            n_err++;
            $display("FAIL fwd_resume: btns_fwd=%h, required 0020", btns_fwd);
        end
        // Bit 0 still held: no second switch may follow.
        tick(150);
        n_vec++;
        if (page_sel !== PW'(model_page) || blank !== 1'b0) begin
            n_err++;
            $display("FAIL held_no_repeat: page_sel=%0d blank=%b, required %0d and 0",
                     page_sel, blank, model_page);
        end
        btns_raw = '0;
        tick(10);
        n_vec++;
        if (btns_fwd !== '0) begin
            n_err++;
            $display("FAIL fwd_release: btns_fwd=%h, required 0000", btns_fwd);
        end
    endtask

    task automatic test_dropped();
        int k = 0;
        wait_pos(20);
        model_page = step_page(model_page, 1'b1);
        exp_q.push_back(model_page);
        btns_raw[0] = 1'b1;
        tick(20);
        btns_raw = '0;
        wait_pos(90);
        tick(1);
        wait_pos(20);
        btns_raw[0] = 1'b1;
        tick(20);
        btns_raw = '0;
        while (blank === 1'b1 && k < 400) begin
            tick(1);
            k++;
        end
        tick(250);
        n_vec++;
        if (page_sel !== PW'(model_page) || blank !== 1'b0) begin
            n_err++;
            $display("FAIL dropped: page_sel=%0d blank=%b, required %0d and 0",
                     page_sel, blank, model_page);
        end
    endtask

    task automatic check_reset_now(input string name);
        n_vec++;
        if (page_sel !== '0 || blank !== 1'b0 || btns_fwd !== '0) begin
            n_err++;
            $display("FAIL %s: page_sel=%0d blank=%b btns_fwd=%h, required 0 0 0000",
                     name, page_sel, blank, btns_fwd);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        if (model_page == 0) switch_once(1'b1, "rm_setup");
        // Reset while PENDING.
        wait_pos(20);
        exp_q.push_back(step_page(model_page, 1'b1));
        btns_raw[0] = 1'b1;
        tick(20);
        btns_raw = '0;
        wait_pos(50);
        rst = 1'b1;
        #1;
        check_reset_now("reset_pending");
        tick(1);
        rst = 1'b0;
        model_page = 0;
        exp_q.delete();
        repeat (150) begin
            tick(1);
            if (page_sel !== '0 || blank !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_pending_after: %0d bad cycles, required 0", bad);
        end
        // Reset while BLANK on page 2.
        while (model_page != 1) switch_once(1'b1, "rm_walk");
        wait_pos(20);
        model_page = step_page(model_page, 1'b1);
        exp_q.push_back(model_page);
        btns_raw[0] = 1'b1;
        tick(20);
        btns_raw = '0;
        wait_pos(90);
        tick(1);
        n_vec++;
        if (page_sel !== PW'(2) || blank !== 1'b1) begin
            n_err++;
            $display("FAIL reset_blank_setup: page_sel=%0d blank=%b, required 2 and 1",
                     page_sel, blank);
        end
        wait_pos(30);
        rst = 1'b1;
        #1;
        check_reset_now("reset_blank");
        tick(1);
        rst = 1'b0;
        model_page = 0;
        exp_q.delete();
        bad = 0;
        repeat (250) begin
            tick(1);
            if (page_sel !== '0 || blank !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_blank_after: %0d bad cycles, required 0", bad);
        end
    endtask

    initial begin
        rst      = 1'b1;
        btns_raw = '0;
        test_reset();
        test_next_press();
        test_wrap();
        test_bounce_merge();
        test_fwd_mask();
        test_dropped();
        test_reset_mid();
        tick(5);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d switches outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/page_switch_ctrl.md
# page_switch_ctrl

Synchronous page scheduler for the VGA page system. It debounces the matrix-keypad button bus and turns next/prev presses into page-index changes. Each change is committed only at a vertical-blank boundary and is followed by a programmable run of black frames. Only the active page receives button input, and only while no switch is in progress. It sits between `mat_key`/`VGA` and the per-page pixel and button muxes. It replaces the button-edge-clocked page register.

## Interface
- `NUM_PAGES`, 3: number of pages; legal range 2..16
- `BTN_W`, 16: button bus width
- `NEXT_IDX`, 0: button bit that advances the page
- `PREV_IDX`, 1: button bit that goes back one page
- `DEB_CYCLES`, 65536: number of consecutive stable `clk` cycles needed to accept a new button level; minimum 1
- `BLANK_FRAMES`, 2: number of full black frames after each switch; 0 is legal
- `clk`  in  1  single clock domain (the VGA pixel clock)
- `rst`  in  1  asynchronous, active-high reset
- `btns_raw`  in  `BTN_W`  raw button levels from `mat_key`; asynchronous to `clk`
- `vblank`  in  1  high during vertical blanking, synchronous to `clk`
- `page_sel`  out  `$clog2(NUM_PAGES)`  active page index; drives the pixel mux
- `blank`  out  1  forces the pixel output to 0x000 while high
- `btns_fwd`  out  `BTN_W`  debounced buttons for the active page

## Operation
- **Input synchronisation:** each bit of `btns_raw` passes through a 2-flop synchroniser.
- **Debounce, per bit:**
  - A counter increments while the synchronised bit differs from the debounced bit.
  - The counter clears whenever the two match.
  - When the counter reaches `DEB_CYCLES`, the debounced bit takes the synchronised value and the counter clears.
- **Press event:** a debounced 0→1 transition on `NEXT_IDX` or `PREV_IDX`, registered for one cycle.
- **FSM states:** `IDLE`, `PENDING`, `BLANK`.
  - `IDLE`: a single press event latches a direction (+1 or −1) and moves to `PENDING`.
    - Next and prev press events in the same cycle cancel; no request is made.
  - `PENDING`: on a `vblank` rising edge (`vblank`=1, previous sample 0):
    - `page_sel` takes its new value.
    - The blank-frame counter clears.
    - The FSM moves to `BLANK`, or to `IDLE` if `BLANK_FRAMES`=0.
  - `BLANK`: each `vblank` rising edge increments the frame counter. When the count reaches `BLANK_FRAMES`, the FSM moves to `IDLE`.
  - Press events outside `IDLE` are dropped and are not queued.
- **Page wrap:**
  - next from `NUM_PAGES-1` goes to 0
  - prev from 0 goes to `NUM_PAGES-1`
  - The arithmetic runs at `$clog2(NUM_PAGES)`+1 bits, with an explicit compare for the wrap, never a modulo.
- **`blank`:** high in `BLANK`; low otherwise.
- **`btns_fwd`:**
  - In `IDLE`: the debounced bus with bits `NEXT_IDX` and `PREV_IDX` forced to 0.
  - In `PENDING` and `BLANK`: all zeros.
- **Held buttons:** a button held through a switch produces no second event. A press event requires a new debounced rise.
- **Reset (asynchronous):**
  - `page_sel`=0, `blank`=0, `btns_fwd`=0
  - FSM=`IDLE`
  - Synchronisers, debounced bits, counters and edge registers all 0
  - Reset mid-switch abandons the switch; `page_sel` returns to 0.

## Timing
- **Raw edge to debounced change:** 2 cycles (synchroniser) + `DEB_CYCLES` cycles.
- **Debounced rise to press event:** 1 cycle.
- **Press event to `PENDING`:** state changes on the next edge.
- **`vblank` rising edge (first cycle `vblank`=1) to `page_sel`/`blank` update:** both update together on the next `clk` edge, i.e. visible 1 cycle after the edge.
- **`blank` deassert:** 1 cycle after the `BLANK_FRAMES`-th counted `vblank` rise. The first rise counted is the one after the switch.
- **`btns_fwd`:** registered; 1 cycle after the debounced value or state changes.
- **Request during `vblank`=1 already high:** waits for the next rising edge, so the switch never lands mid-blank-interval.

## Structure
- **Package `page_pkg`:**
  - FSM state enum `page_state_t` (`IDLE`, `PENDING`, `BLANK`)
  - `PAGE_IDX_W` function of `NUM_PAGES`
  - Default `NEXT_IDX`/`PREV_IDX`
- **Sub-module `btn_debounce`:** parameters `WIDTH` and `DEB_CYCLES`; contains the synchroniser, per-bit counters and debounced register.
- **Top:** the FSM, wrap logic and output masking stay in `page_switch_ctrl`.

## Test plan
All scenarios use `NUM_PAGES`=3, `DEB_CYCLES`=4, `BLANK_FRAMES`=2. A frame is 100 cycles, with `vblank` high for the last 10 of them.

1. **Next press:**
   - Stimulus: press bit 0 for 20 cycles mid-frame.
   - Response: `page_sel` 0→1 exactly 1 cycle after the next `vblank` rise; `blank` high for 2 frames; `btns_fwd`=0 throughout.
2. **Wrap-around:**
   - Stimulus: three next presses, each completing its switch.
   - Response: `page_sel` steps 0→1→2→0.
   - Stimulus: from 0, one prev press.
   - Response: `page_sel`=2.
3. **Bounce and press merging:**
   - Stimulus: bit 0 toggles every 2 cycles for 30 cycles, then goes low.
   - Response: no page change.
   - Stimulus: simultaneous next+prev debounced rises.
   - Response: FSM stays `IDLE`, `page_sel` unchanged.
4. **Forwarding mask:**
   - Stimulus: in `IDLE`, hold bits 5 and 0.
   - Response: `btns_fwd`=0x0020 after 2+4+1 cycles. During the resulting `PENDING`/`BLANK` states, `btns_fwd`=0x0000.
5. **Dropped request:**
   - Stimulus: a second next press during `BLANK`.
   - Response: ignored; `page_sel` advances by 1 only.
6. **Reset mid-switch:**
   - Stimulus: assert `rst` for 1 cycle while in `PENDING`, and separately while in `BLANK` with `page_sel`=2.
   - Response: immediate `page_sel`=0, `blank`=0, `btns_fwd`=0; no switch at the next `vblank` rise.
